// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pio_pkg
//  Purpose  : Shared constants for the PIO block (word width, FIFO depth,
//             flag_clr bit positions).
//  Revision : 1.0  initial release
// ============================================================================
package pio_pkg;

  localparam int PIO_WORD_W     = 32;
  localparam int PIO_FIFO_DEPTH = 4;

  // Bit positions inside the write-1-to-clear flag_clr vector
  localparam int FLAG_OVERFLOW  = 0;
  localparam int FLAG_STALL     = 1;

endpackage : pio_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ptr
//  Purpose  : Wrapping pointer counter with enable, synchronous clear and a
//             run-time modulo (the FIFO's effective depth).
//  Revision : 1.0  initial release
// ============================================================================
module fifo_ptr
  import pio_pkg::*;
#(
  parameter int PW = 2
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic [PW:0]   i_mod,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;
  logic [PW:0]   w_inc;

  // Increment one bit wider than the pointer so the modulo value itself
  // (which may equal 2**PW) can be compared without truncation.
  assign w_inc = {1'b0, r_ptr} + 1'b1;

  // Pointer register: clear wins, otherwise advance and wrap at i_mod
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (w_inc == i_mod) ? '0 : w_inc[PW-1:0];
    end
  end

  assign o_ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/machine_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : machine_fifo
//  Purpose  : First-word-fall-through word FIFO between the system bus and a
//             PIO state machine, with occupancy level and sticky
//             overflow / stall debug flags.
//  Options  : MACHINE_FIFO_JOIN_EN - enables i_join (doubles the depth).
//  Revision : 1.0  initial release
// ============================================================================
module machine_fifo
  import pio_pkg::*;
#(
  parameter  int WIDTH = PIO_WORD_W,
  parameter  int DEPTH = PIO_FIFO_DEPTH,
  localparam int LW    = $clog2(2*DEPTH) + 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [LW-1:0]    o_level,
  input  logic             i_join,
  input  logic [1:0]       i_flag_clr,
  output logic             o_overflow,
  output logic             o_stall
);

`ifdef MACHINE_FIFO_JOIN_EN
  localparam int NSLOT = 2*DEPTH;
`else
  localparam int NSLOT = DEPTH;
`endif
  localparam int PW = $clog2(NSLOT);

  logic [WIDTH-1:0] r_mem [NSLOT];
  logic [PW-1:0]    w_rd_ptr;
  logic [PW-1:0]    w_wr_ptr;
  logic [PW:0]      w_eff;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;
  logic             r_stall;
  logic             w_flush;
  logic             w_do_wr;
  logic             w_do_rd;
  logic             w_ovf_set;
  logic             w_stall_set;

`ifdef MACHINE_FIFO_JOIN_EN
  logic r_join;

  // Registered join; any change flushes in the cycle it is sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_join <= 1'b0;
    end else begin
      r_join <= i_join;
    end
  end

  assign w_flush = i_clear | (i_join != r_join);
  assign w_eff   = r_join ? (PW+1)'(2*DEPTH) : (PW+1)'(DEPTH);
`else
  logic w_unused_join;
  assign w_unused_join = i_join;
  assign w_flush       = i_clear;
  assign w_eff         = (PW+1)'(DEPTH);
`endif

  // A pop frees a slot in the same edge, so a write into a full FIFO is
  // accepted when paired with a pop. Empty+pop is never bypassed.
  assign w_do_rd     = i_rd_en & ~r_empty & ~w_flush;
  assign w_do_wr     = i_wr_en & (~r_full | w_do_rd) & ~w_flush;
  assign w_ovf_set   = i_wr_en & r_full & ~w_do_rd & ~w_flush;
  assign w_stall_set = i_rd_en & r_empty & ~w_flush;

  fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_flush),
    .i_en    (w_do_rd),
    .i_mod   (w_eff),
    .o_ptr   (w_rd_ptr)
  );

  fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_flush),
    .i_en    (w_do_wr),
    .i_mod   (w_eff),
    .o_ptr   (w_wr_ptr)
  );

  // Next occupancy: +1 write-only, -1 pop-only, 0 on flush
  always_comb begin
    w_level_nxt = r_level;
    if (w_flush) begin
      w_level_nxt = '0;
    end else if (w_do_wr && !w_do_rd) begin
      w_level_nxt = r_level + 1'b1;
    end else if (!w_do_wr && w_do_rd) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  // Level plus registered empty/full derived from the next level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LW'(w_eff));
    end
  end

  // Storage array; reset to zero so the head reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_wr) begin
      r_mem[w_wr_ptr] <= i_wr_data;
    end
  end

  // Sticky flags: a same-cycle set beats the write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_overflow <= w_ovf_set   | (r_overflow & ~i_flag_clr[FLAG_OVERFLOW]);
      r_stall    <= w_stall_set | (r_stall    & ~i_flag_clr[FLAG_STALL]);
    end
  end

  assign o_rd_data  = r_mem[w_rd_ptr];
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_level    = r_level;
  assign o_overflow = r_overflow;
  assign o_stall    = r_stall;

endmodule : machine_fifo
`default_nettype wire
